// File: rtl/sga_pkg.sv
// ----------------------------------------------------------------------------
// sga_pkg
// Purpose : Shared definitions for the snake game input path and datapath.
//           Holds the direction codes, the reverse-direction rule and a
//           helper for sizing counters from a cycle-count parameter.
// Contents: dir_e        - 2-bit move direction code
//           is_reverse() - 1 when two codes point in opposite directions
//           cnt_width()  - clog2 of a count, never less than 1
// ----------------------------------------------------------------------------
package sga_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    // Opposite directions share the axis bit [1] and differ in the sense bit [0].
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // Width of a counter that runs 0..n-1; a 1-cycle count still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sga_debouncer.sv
// ----------------------------------------------------------------------------
// sga_debouncer
// Purpose : One push-button conditioner: 2-flop synchronizer, debounce filter
//           and a one-cycle pulse on each accepted 0->1 level change.
// Ports   : clk_i   - system clock
//           rst_i   - asynchronous active-high reset
//           clr_i   - synchronous clear of all state
//           btn_i   - raw asynchronous button level
//           press_o - one-cycle pulse when the stable level rises
// ----------------------------------------------------------------------------
module sga_debouncer
    import sga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          mismatch;
    logic          done;

    // The count holds the number of consecutive mismatch cycles already seen;
    // the level flips on the cycle that completes the full run.
    assign mismatch = sync2_q ^ stable_q;
    assign done     = mismatch && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // Only a rising change of the stable level is a press.
            press_q <= done && sync2_q;
            if (!mismatch) begin
                cnt_q <= '0;
            end else if (done) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sga_input_control.sv
// ----------------------------------------------------------------------------
// sga_input_control
// Purpose : Turns four raw push-buttons into a snake move direction and
//           produces the periodic move-step pulse.
// Ports   : clock             - system clock
//           reset             - asynchronous active-high reset
//           buttons[3:0]      - raw buttons: [0] right, [1] left, [2] up, [3] down
//           restart           - synchronous clear of the game input state
//           pause             - freezes the move timer and ignores presses
//           enable            - high while the game is playing
//           direction[1:0]    - committed move direction
//           pending_direction - direction committed at the next move step
//           end_play_time     - one-cycle pulse marking a move step
//           press_accepted    - one-cycle pulse when pending_direction loads
// ----------------------------------------------------------------------------
module sga_input_control
    import sga_pkg::*;
#(
    parameter int TICK_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons,
    input  logic       restart,
    input  logic       pause,
    input  logic       enable,
    output logic [1:0] direction,
    output logic [1:0] pending_direction,
    output logic       end_play_time,
    output logic       press_accepted
);

    localparam int unsigned   TW        = cnt_width(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [3:0]    press_w;
    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [1:0]    direction_q;
    logic [1:0]    pending_q;
    logic          press_accepted_q;
    logic          counting;
    logic          tick;
    logic          accept;
    dir_e          win;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        sga_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk_i  (clock),
            .rst_i  (reset),
            .clr_i  (restart),
            .btn_i  (buttons[gi]),
            .press_o(press_w[gi])
        );
    end

    // Lowest button index wins; button index equals its direction code.
    always_comb begin
        win = DIR_RIGHT;
        casez (press_w)
            4'b???1: win = DIR_RIGHT;
            4'b??10: win = DIR_LEFT;
            4'b?100: win = DIR_UP;
            4'b1000: win = DIR_DOWN;
            default: win = DIR_RIGHT;
        endcase
    end

    assign counting = enable && !pause;
    // restart wins over a move step, so no step pulse is shown in that cycle.
    assign tick     = counting && !restart && (cnt_q == TICK_LAST);
    // Presses are judged against the committed direction, never the pending one.
    assign accept   = (|press_w) && counting && !is_reverse(win, direction_q);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q            <= '0;
            direction_q      <= DIR_RIGHT;
            pending_q        <= DIR_RIGHT;
            press_accepted_q <= 1'b0;
        end else if (restart) begin
            cnt_q            <= '0;
            direction_q      <= DIR_RIGHT;
            pending_q        <= DIR_RIGHT;
            press_accepted_q <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            press_accepted_q <= accept;
            // Commit uses the old pending value; a same-cycle press loads after.
            if (tick) begin
                direction_q <= pending_q;
            end
            if (accept) begin
                pending_q <= win;
            end
        end
    end

    assign direction         = direction_q;
    assign pending_direction = pending_q;
    assign end_play_time     = tick;
    assign press_accepted    = press_accepted_q;

endmodule

// File: tb/tb_sga_input_control.sv
// ----------------------------------------------------------------------------
// tb_sga_input_control
// Directed scenarios followed by random button/pause/enable/restart traffic.
// A cycle-level reference model predicts every move step and every accepted
// press; predictions are queued with their cycle number and a separate monitor
// compares them with what the design shows.
// ----------------------------------------------------------------------------
module tb_sga_input_control;

    localparam int TICK = 8;
    localparam int DEB  = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       restart = 1'b0;
    logic       pause   = 1'b0;
    logic       enable  = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic [1:0] direction;
    logic [1:0] pending_direction;
    logic       end_play_time;
    logic       press_accepted;

    always #5 clock = ~clock;

    sga_input_control #(
        .TICK_CYCLES    (TICK),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .buttons          (buttons),
        .restart          (restart),
        .pause            (pause),
        .enable           (enable),
        .direction        (direction),
        .pending_direction(pending_direction),
        .end_play_time    (end_play_time),
        .press_accepted   (press_accepted)
    );

    typedef struct packed {
        int         cyc;
        logic       tick;
        logic       acc;
        logic [1:0] dir;
        logic [1:0] pend;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  edge_cnt = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model state ----------------
    int         m_cnt;
    logic [1:0] m_dir;
    logic [1:0] m_pend;
    logic       m_acc;
    logic [3:0] m_stable;
    logic [3:0] m_press;
    int         m_run [4];
    logic [3:0] hq[$];   // raw levels as seen two cycles late

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_dir    = 2'b00;
        m_pend   = 2'b00;
        m_acc    = 1'b0;
        m_stable = 4'b0000;
        m_press  = 4'b0000;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        hq.delete();
        hq.push_back(4'b0000);
        hq.push_back(4'b0000);
    endtask

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_cycle();
        logic       tick;
        logic       accept;
        logic [1:0] win;
        logic [3:0] s;
        logic [3:0] np;
        ev_t        e;
        tick = enable && !pause && !restart && (m_cnt == TICK - 1);
        if (tick || m_acc) begin
            e.cyc  = edge_cnt;
            e.tick = tick;
            e.acc  = m_acc;
            e.dir  = m_dir;
            e.pend = m_pend;
            exp_q.push_back(e);
        end
        if (restart) begin
            model_reset();
            return;
        end
        s = hq.pop_front();
        hq.push_back(buttons);
        np = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if (s[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_stable[b] = s[b];
                    m_run[b]    = 0;
                    np[b]       = s[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        accept = 1'b0;
        win    = 2'b00;
        for (int b = 3; b >= 0; b--) begin
            if (m_press[b]) begin
                win    = 2'(b);
                accept = 1'b1;
            end
        end
        // opposite of a direction: flip its sense bit
        if (!enable || pause || (win == (m_dir ^ 2'b01))) accept = 1'b0;
        if (tick) begin
            m_dir = m_pend;
            m_cnt = 0;
        end else if (enable && !pause) begin
            m_cnt++;
        end
        if (accept) m_pend = win;
        m_acc   = accept;
        m_press = np;
    endtask

    // ---------------- monitor ----------------
    ev_t mon_e;
    bit  mon_has;
    always @(negedge clock) begin
        if (!reset) begin
            mon_has = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
            if (mon_has) begin
                mon_e = exp_q.pop_front();
                check("event{tick,acc,dir,pend}",
                      {2'b00, end_play_time, press_accepted, direction, pending_direction},
                      {2'b00, mon_e.tick, mon_e.acc, mon_e.dir, mon_e.pend});
            end else if (end_play_time || press_accepted) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d: got tick=%b acc=%b want none",
                         edge_cnt, end_play_time, press_accepted);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] b, input logic en, input logic ps, input logic rs);
        @(posedge clock);
        #1;
        buttons = b;
        enable  = en;
        pause   = ps;
        restart = rs;
        model_cycle();
    endtask

    task automatic reset_pulse();
        @(posedge clock);
        #1;
        reset   = 1'b1;
        restart = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check("rst_direction", 8'(direction), 8'h0);
        check("rst_pending", 8'(pending_direction), 8'h0);
        check("rst_end_play_time", 8'(end_play_time), 8'h0);
        check("rst_press_accepted", 8'(press_accepted), 8'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_cycle();
    endtask

    int         lat;
    int         guard;
    logic [3:0] rb;
    logic       ren;
    logic       rps;

    initial begin
        model_reset();
        reset_pulse();

        // periodic move steps, direction stays right
        repeat (24) drive(4'b0000, 1'b1, 1'b0, 1'b0);

        // left is the reverse of right: rejected
        repeat (8) drive(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (8) drive(4'b0000, 1'b1, 1'b0, 1'b0);
        check("pending_after_reverse", 8'(pending_direction), 8'h0);
        // short glitch on down never debounces
        repeat (2) drive(4'b1000, 1'b1, 1'b0, 1'b0);
        repeat (8) drive(4'b0000, 1'b1, 1'b0, 1'b0);

        // up held 10 cycles; accept pulse 5 or 6 cycles after the edge
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            drive(4'b0100, 1'b1, 1'b0, 1'b0);
            #3;
            if (press_accepted && lat < 0) lat = i;
        end
        check("press_latency_5_or_6", 8'(lat >= 5 && lat <= 6), 8'h1);
        check("pending_up", 8'(pending_direction), 8'h2);
        repeat (16) drive(4'b0000, 1'b1, 1'b0, 1'b0);
        check("direction_up", 8'(direction), 8'h2);

        // right, then up+down together (up wins), then pause and resume
        repeat (6) drive(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (6) drive(4'b1100, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(4'b0000, 1'b1, 1'b0, 1'b0);
        check("pending_dual_press", 8'(pending_direction), 8'h2);
        repeat (20) drive(4'b0000, 1'b1, 1'b1, 1'b0);
        repeat (16) drive(4'b0000, 1'b1, 1'b0, 1'b0);

        // left becomes pending, then restart lands on the move-step cycle
        repeat (6) drive(4'b0010, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_cnt != TICK - 1 && guard < 20) begin
            drive(4'b0000, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        drive(4'b0000, 1'b1, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        #3;
        check("restart_direction", 8'(direction), 8'h0);
        check("restart_pending", 8'(pending_direction), 8'h0);
        check("restart_press_accepted", 8'(press_accepted), 8'h0);

        // reset mid-count with right held through release
        repeat (3) drive(4'b0001, 1'b1, 1'b0, 1'b0);
        reset_pulse();
        repeat (10) drive(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(4'b0000, 1'b1, 1'b0, 1'b0);

        // random traffic
        rb  = 4'b0000;
        ren = 1'b1;
        rps = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rb = 4'($urandom);
            if ($urandom_range(0, 59) == 0) ren = ~ren;
            if ($urandom_range(0, 39) == 0) rps = ~rps;
            if ($urandom_range(0, 799) == 0) begin
                reset_pulse();
            end else begin
                drive(rb, ren, rps, 1'($urandom_range(0, 299) == 0));
            end
        end

        repeat (10) drive(4'b0000, 1'b0, 1'b0, 1'b0);
        check("queue_drained", 8'(exp_q.size()), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
